// File: rtl/lc4_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : lc4_wb_sched
// Purpose  : Dual-pipe LC4 write-back scheduler. Pipe writes pass straight
//            through; long-latency (X) results queue in a FIFO and drain into
//            idle write-port slots, with stale entries killed by younger
//            pipe writes.
// Revision : 1.0 - initial release
// ============================================================================
module lc4_wb_sched #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       gwe,
    input  logic                       rst,
    input  logic                       i_wb_we_A,
    input  logic [2:0]                 i_wb_rd_A,
    input  logic [N-1:0]               i_wb_data_A,
    input  logic                       i_wb_we_B,
    input  logic [2:0]                 i_wb_rd_B,
    input  logic [N-1:0]               i_wb_data_B,
    input  logic                       i_x_valid,
    input  logic [2:0]                 i_x_rd,
    input  logic [N-1:0]               i_x_data,
    output logic                       o_x_ready,
    output logic                       o_rd_we_A,
    output logic [2:0]                 o_rd_A,
    output logic [N-1:0]               o_wdata_A,
    output logic                       o_rd_we_B,
    output logic [2:0]                 o_rd_B,
    output logic [N-1:0]               o_wdata_B,
    output logic [7:0]                 o_pending,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    c_FULL = (AW+1)'(DEPTH);

    logic [2:0]       r_rd   [DEPTH];
    logic [N-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    logic [DEPTH-1:0] w_kill;
    logic [AW-1:0]    w_h0;
    logic [AW-1:0]    w_h1;
    logic             w_en;
    logic             w_live0;
    logic             w_live1;
    logic             w_free_A;
    logic             w_free_B;
    logic             w_pop0;
    logic             w_pop1;
    logic [1:0]       w_npop;
    logic             w_push;
    logic [7:0]       w_pend;

    assign w_en     = gwe & ~rst;
    assign w_h0     = r_head;
    assign w_h1     = r_head + AW'(1);
    assign w_free_A = ~i_wb_we_A;
    assign w_free_B = ~i_wb_we_B;
    assign w_npop   = {1'b0, w_pop0} + {1'b0, w_pop1};
    assign w_push   = gwe & i_x_valid & (r_count != c_FULL);

    // A pipe write to the same rd makes a buffered (older) result stale.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = (i_wb_we_A && (i_wb_rd_A == r_rd[i])) ||
                        (i_wb_we_B && (i_wb_rd_B == r_rd[i]));
        end
    end

    // Dead entries have r_live cleared, so liveness alone decides draining.
    assign w_live0 = r_live[w_h0] & ~w_kill[w_h0];
    assign w_live1 = r_live[w_h1] & ~w_kill[w_h1];

    always_comb begin
        o_rd_we_A = i_wb_we_A;
        o_rd_A    = i_wb_rd_A;
        o_wdata_A = i_wb_data_A;
        o_rd_we_B = i_wb_we_B;
        o_rd_B    = i_wb_rd_B;
        o_wdata_B = i_wb_data_B;
        w_pop0    = 1'b0;
        w_pop1    = 1'b0;
        if (w_en && (r_count != '0)) begin
            if (!w_live0 || w_free_A || w_free_B) begin
                w_pop0 = 1'b1;
                if (w_live0) begin
                    if (w_free_A) begin
                        o_rd_we_A = 1'b1;
                        o_rd_A    = r_rd[w_h0];
                        o_wdata_A = r_data[w_h0];
                    end else begin
                        o_rd_we_B = 1'b1;
                        o_rd_B    = r_rd[w_h0];
                        o_wdata_B = r_data[w_h0];
                    end
                end
                if (r_count > (AW+1)'(1)) begin
                    if (!w_live1) begin
                        w_pop1 = 1'b1;
                    end else if (!w_live0 && (w_free_A || w_free_B)) begin
                        w_pop1 = 1'b1;
                        if (w_free_A) begin
                            o_rd_we_A = 1'b1;
                            o_rd_A    = r_rd[w_h1];
                            o_wdata_A = r_data[w_h1];
                        end else begin
                            o_rd_we_B = 1'b1;
                            o_rd_B    = r_rd[w_h1];
                            o_wdata_B = r_data[w_h1];
                        end
                    end else if (w_free_A && w_free_B) begin
                        // Younger entry on B so a same-rd pair resolves to it.
                        w_pop1    = 1'b1;
                        o_rd_we_B = 1'b1;
                        o_rd_B    = r_rd[w_h1];
                        o_wdata_B = r_data[w_h1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_live  <= '0;
        end else if (gwe) begin
            r_head  <= r_head + AW'(w_npop);
            r_tail  <= r_tail + AW'(w_push);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_npop);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i] || (w_pop0 && (AW'(i) == w_h0)) ||
                    (w_pop1 && (AW'(i) == w_h1))) begin
                    r_live[i] <= 1'b0;
                end
            end
            // The tail slot is free, so the new entry is never self-killed.
            if (w_push) begin
                r_live[r_tail] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_rd[r_tail]   <= i_x_rd;
            r_data[r_tail] <= i_x_data;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) begin
                w_pend[r_rd[i]] = 1'b1;
            end
        end
    end

    assign o_pending = w_pend;
    assign o_count   = r_count;
    assign o_x_ready = (r_count != c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_lc4_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc4_wb_sched
// Purpose  : Self-checking bench for lc4_wb_sched: directed vector table
//            followed by a randomized phase against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc4_wb_sched;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        gwe, rst;
    logic        we_A, we_B, x_valid;
    logic [2:0]  rd_A, rd_B, x_rd;
    logic [15:0] data_A, data_B, x_data;
    logic        x_ready, o_we_A, o_we_B;
    logic [2:0]  o_rd_A, o_rd_B;
    logic [15:0] o_wd_A, o_wd_B;
    logic [7:0]  pending;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lc4_wb_sched #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .gwe(gwe), .rst(rst),
        .i_wb_we_A(we_A), .i_wb_rd_A(rd_A), .i_wb_data_A(data_A),
        .i_wb_we_B(we_B), .i_wb_rd_B(rd_B), .i_wb_data_B(data_B),
        .i_x_valid(x_valid), .i_x_rd(x_rd), .i_x_data(x_data),
        .o_x_ready(x_ready),
        .o_rd_we_A(o_we_A), .o_rd_A(o_rd_A), .o_wdata_A(o_wd_A),
        .o_rd_we_B(o_we_B), .o_rd_B(o_rd_B), .o_wdata_B(o_wd_B),
        .o_pending(pending), .o_count(count)
    );

    // Port/X fields packed as {we, rd[2:0], data[15:0]}.
    typedef struct {
        logic        rst, gwe, chk;
        logic [19:0] pa, pb, px;
        logic [19:0] ea, eb;
        logic [2:0]  cnt;
        logic        rdy;
        logic [7:0]  pend;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        live;
    } ent_t;

    ent_t q[$];

    function automatic vec_t mk(logic r, logic g, logic c, logic [19:0] pa, logic [19:0] pb,
                                logic [19:0] px, logic [19:0] ea, logic [19:0] eb,
                                logic [2:0] cnt, logic rdy, logic [7:0] pend);
        vec_t v;
        v.rst = r; v.gwe = g; v.chk = c; v.pa = pa; v.pb = pb; v.px = px;
        v.ea = ea; v.eb = eb; v.cnt = cnt; v.rdy = rdy; v.pend = pend;
        return v;
    endfunction

    task automatic check(string name, logic [51:0] got, logic [51:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got A=%h B=%h cnt=%0d rdy=%b pend=%h, want A=%h B=%h cnt=%0d rdy=%b pend=%h",
                     name, got[51:32], got[31:12], got[11:9], got[8], got[7:0],
                     exp[51:32], exp[31:12], exp[11:9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [51:0] dut_obs();
        return {o_we_A, o_rd_A, o_wd_A, o_we_B, o_rd_B, o_wd_B, count, x_ready, pending};
    endfunction

    function automatic logic killed(logic [2:0] r);
        return (we_A && rd_A == r) || (we_B && rd_B == r);
    endfunction

    localparam logic [19:0] c_IDLE = 20'h00000;
    localparam logic [19:0] c_BA   = 20'hF00A7;
    localparam logic [19:0] c_BB   = 20'hF00B7;

    vec_t tv[30];

    initial begin
        logic [19:0] ea, eb;
        logic [7:0]  ep;
        logic        l0, l1, push_ok;
        int          np;

        tv[0]  = mk(1,1,0, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 0,1,8'h00);
        tv[1]  = mk(0,1,1, c_IDLE,c_IDLE,20'hB1234, c_IDLE,c_IDLE, 0,1,8'h00);
        tv[2]  = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     20'hB1234,c_IDLE, 1,1,8'h08);
        tv[3]  = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 0,1,8'h00);
        tv[4]  = mk(0,1,1, c_BA,c_BB,20'h90011,     c_BA,c_BB, 0,1,8'h00);
        tv[5]  = mk(0,1,1, c_BA,c_BB,20'hA0022,     c_BA,c_BB, 1,1,8'h02);
        tv[6]  = mk(0,1,1, c_BA,c_BB,20'hC0044,     c_BA,c_BB, 2,1,8'h06);
        tv[7]  = mk(0,1,1, c_BA,c_BB,20'hE0066,     c_BA,c_BB, 3,1,8'h16);
        tv[8]  = mk(0,1,1, c_BA,c_BB,20'hD0055,     c_BA,c_BB, 4,0,8'h56);
        tv[9]  = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     20'h90011,20'hA0022, 4,0,8'h56);
        tv[10] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     20'hC0044,20'hE0066, 2,1,8'h50);
        tv[11] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 0,1,8'h00);
        tv[12] = mk(0,1,1, c_BA,c_BB,20'h90101,     c_BA,c_BB, 0,1,8'h00);
        tv[13] = mk(0,1,1, c_BA,c_BB,20'hDAAAA,     c_BA,c_BB, 1,1,8'h02);
        tv[14] = mk(0,1,1, c_BA,20'hD5555,20'h0,    c_BA,20'hD5555, 2,1,8'h22);
        tv[15] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     20'h90101,c_IDLE, 2,1,8'h02);
        tv[16] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 0,1,8'h00);
        tv[17] = mk(0,1,1, c_BA,c_BB,20'hB0033,     c_BA,c_BB, 0,1,8'h00);
        tv[18] = mk(0,1,1, c_BA,c_BB,20'hC0044,     c_BA,c_BB, 1,1,8'h08);
        tv[19] = mk(0,1,1, c_BA,c_IDLE,20'h0,       c_BA,20'hB0033, 2,1,8'h18);
        tv[20] = mk(0,1,1, c_BA,c_IDLE,20'h0,       c_BA,20'hC0044, 1,1,8'h10);
        tv[21] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 0,1,8'h00);
        tv[22] = mk(0,1,1, c_BA,c_BB,20'hA0001,     c_BA,c_BB, 0,1,8'h00);
        tv[23] = mk(0,1,1, c_BA,c_BB,20'hA0002,     c_BA,c_BB, 1,1,8'h04);
        tv[24] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     20'hA0001,20'hA0002, 2,1,8'h04);
        tv[25] = mk(0,1,1, c_BA,c_BB,20'h91111,     c_BA,c_BB, 0,1,8'h00);
        tv[26] = mk(0,1,1, c_BA,c_BB,20'hA2222,     c_BA,c_BB, 1,1,8'h02);
        tv[27] = mk(0,1,1, c_BA,c_BB,20'hB3333,     c_BA,c_BB, 2,1,8'h06);
        tv[28] = mk(1,0,1, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 3,1,8'h0E);
        tv[29] = mk(0,1,1, c_IDLE,c_IDLE,20'h0,     c_IDLE,c_IDLE, 0,1,8'h00);

        rst = 1'b1; gwe = 1'b1;
        {we_A, rd_A, data_A} = '0;
        {we_B, rd_B, data_B} = '0;
        {x_valid, x_rd, x_data} = '0;

        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            rst = tv[i].rst; gwe = tv[i].gwe;
            {we_A, rd_A, data_A}    = tv[i].pa;
            {we_B, rd_B, data_B}    = tv[i].pb;
            {x_valid, x_rd, x_data} = tv[i].px;
            @(negedge clk);
            if (tv[i].chk)
                check($sformatf("vec%0d", i), dut_obs(),
                      {tv[i].ea, tv[i].eb, tv[i].cnt, tv[i].rdy, tv[i].pend});
        end

        // Randomized phase: DUT is empty after the last vector.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 63) == 0);
            gwe     = ($urandom_range(0, 7) != 0);
            we_A    = ($urandom_range(0, 99) < 55);
            rd_A    = 3'($urandom);
            data_A  = 16'($urandom);
            we_B    = ($urandom_range(0, 99) < 55);
            rd_B    = 3'($urandom);
            data_B  = 16'($urandom);
            x_valid = ($urandom_range(0, 99) < 60);
            x_rd    = 3'($urandom);
            x_data  = 16'($urandom);
            @(negedge clk);

            ea = {we_A, rd_A, data_A};
            eb = {we_B, rd_B, data_B};
            ep = '0;
            foreach (q[k]) if (q[k].live) ep[q[k].rd] = 1'b1;
            np = 0;
            if (!rst && gwe && q.size() > 0) begin
                l0 = q[0].live && !killed(q[0].rd);
                if (!l0 || !we_A || !we_B) begin
                    np = 1;
                    if (l0) begin
                        if (!we_A) ea = {1'b1, q[0].rd, q[0].data};
                        else       eb = {1'b1, q[0].rd, q[0].data};
                    end
                    if (q.size() > 1) begin
                        l1 = q[1].live && !killed(q[1].rd);
                        if (!l1) begin
                            np = 2;
                        end else if (!l0 && (!we_A || !we_B)) begin
                            np = 2;
                            if (!we_A) ea = {1'b1, q[1].rd, q[1].data};
                            else       eb = {1'b1, q[1].rd, q[1].data};
                        end else if (!we_A && !we_B) begin
                            np = 2;
                            eb = {1'b1, q[1].rd, q[1].data};
                        end
                    end
                end
            end
            check($sformatf("rand%0d", c), dut_obs(),
                  {ea, eb, 3'(q.size()), (q.size() != DEPTH), ep});

            if (rst) begin
                q.delete();
            end else if (gwe) begin
                push_ok = x_valid && (q.size() < DEPTH);
                foreach (q[k]) if (killed(q[k].rd)) q[k].live = 1'b0;
                repeat (np) void'(q.pop_front());
                if (push_ok) q.push_back('{rd: x_rd, data: x_data, live: 1'b1});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
